rv16c_fetch_aligner: RTL and testbench



---
 rtl/rv16c_fetch_aligner.sv | 226 ++++++++++++++++++++++
 tb/tb_rv16c_fetch_aligner.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv16c_fetch_aligner.sv
// Fetch aligner: buffers 32-bit fetch words as halfwords, realigns mixed 16/32-bit
// streams and expands RV32C to 32-bit. Optional macro RV16C_ILLEGAL_TRAP_EN flags illegal encodings.
module rv16c_fetch_aligner #(
  parameter int              BUF_HW   = 4,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_fetch_valid,
  input  logic [31:0]     i_fetch_data,
  output logic            o_fetch_ready,
  input  logic            i_flush,
  input  logic [PC_W-1:0] i_flush_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic [PC_W-1:0] o_pc,
  output logic            o_is_compressed,
  output logic            o_illegal
);

  // Both interfaces use valid/ready: a transfer happens on a rising edge where valid && ready;
  // the producer holds its payload stable while valid && !ready.
  localparam int PTR_W = $clog2(BUF_HW);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] BUF_CNT  = CNT_W'(BUF_HW);
  localparam logic [31:0]      NOP      = 32'h0000_0013;
  localparam logic [6:0]       OP_IMM   = 7'h13;
  localparam logic [6:0]       OP_LOAD  = 7'h03;
  localparam logic [6:0]       OP_STORE = 7'h23;
  localparam logic [6:0]       OP_LUI   = 7'h37;
  localparam logic [6:0]       OP_REG   = 7'h33;
  localparam logic [6:0]       OP_JAL   = 7'h6f;
  localparam logic [6:0]       OP_JALR  = 7'h67;
  localparam logic [6:0]       OP_BR    = 7'h63;

  // Returns {illegal, expanded}; expanded is NOP whenever illegal is set.
  function automatic logic [32:0] expand_c(input logic [15:0] h);
    logic [31:0] r;
    logic        ill;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6s;
    r     = NOP;
    ill   = 1'b0;
    rd    = h[11:7];
    rs2   = h[6:2];
    rdp   = {2'b01, h[4:2]};
    rs1p  = {2'b01, h[9:7]};
    imm6s = {{7{h[12]}}, h[6:2]};
    case (h[1:0])
      2'b00: begin
        case (h[15:13])
          3'b000: begin
            if (h[12:5] == 8'd0) ill = 1'b1;
            else r = {2'b00, h[10:7], h[12:11], h[5], h[6], 2'b00, 5'd2, 3'b000, rdp, OP_IMM};
          end
          3'b010:  r = {5'b0, h[5], h[12:10], h[6], 2'b00, rs1p, 3'b010, rdp, OP_LOAD};
          3'b110:  r = {5'b0, h[5], h[12], rdp, rs1p, 3'b010, h[11:10], h[6], 2'b00, OP_STORE};
          default: ill = 1'b1;
        endcase
      end
      2'b01: begin
        case (h[15:13])
          3'b000: r = {imm6s, rd, 3'b000, rd, OP_IMM};
          3'b001, 3'b101:
            r = {h[12], h[8], h[10:9], h[6], h[7], h[2], h[11], h[5:3], h[12], {8{h[12]}},
                 (h[15] ? 5'd0 : 5'd1), OP_JAL};
          3'b010: r = {imm6s, 5'd0, 3'b000, rd, OP_IMM};
          3'b011: begin
            if ({h[12], h[6:2]} == 6'd0) ill = 1'b1;
            else if (rd == 5'd2)
              r = {{3{h[12]}}, h[4:3], h[5], h[2], h[6], 4'b0000, 5'd2, 3'b000, 5'd2, OP_IMM};
            else r = {{15{h[12]}}, h[6:2], rd, OP_LUI};
          end
          3'b100: begin
            case (h[11:10])
              2'b00: begin
                if (h[12]) ill = 1'b1;
                else r = {7'b0000000, h[6:2], rs1p, 3'b101, rs1p, OP_IMM};
              end
              2'b01: begin
                if (h[12]) ill = 1'b1;
                else r = {7'b0100000, h[6:2], rs1p, 3'b101, rs1p, OP_IMM};
              end
              2'b10: r = {imm6s, rs1p, 3'b111, rs1p, OP_IMM};
              default: begin
                // h[12]=1 selects the RV64-only SUBW/ADDW group
                if (h[12]) ill = 1'b1;
                else begin
                  case (h[6:5])
                    2'b00:   r = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG};
                    2'b01:   r = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_REG};
                    2'b10:   r = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_REG};
                    default: r = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_REG};
                  endcase
                end
              end
            endcase
          end
          default:
            r = {{4{h[12]}}, h[6:5], h[2], 5'd0, rs1p, {2'b00, h[13]}, h[11:10], h[4:3], h[12], OP_BR};
        endcase
      end
      2'b10: begin
        case (h[15:13])
          3'b000: begin
            if (h[12]) ill = 1'b1;
            else r = {7'b0000000, h[6:2], rd, 3'b001, rd, OP_IMM};
          end
          3'b010: begin
            if (rd == 5'd0) ill = 1'b1;
            else r = {4'b0000, h[3:2], h[12], h[6:4], 2'b00, 5'd2, 3'b010, rd, OP_LOAD};
          end
          3'b100: begin
            if (!h[12]) begin
              if (rs2 != 5'd0) r = {7'b0, rs2, 5'd0, 3'b000, rd, OP_REG};
              else if (rd == 5'd0) ill = 1'b1;
              else r = {12'd0, rd, 3'b000, 5'd0, OP_JALR};
            end else begin
              if (rs2 != 5'd0) r = {7'b0, rs2, rd, 3'b000, rd, OP_REG};
              else if (rd == 5'd0) r = 32'h0010_0073;
              else r = {12'd0, rd, 3'b000, 5'd1, OP_JALR};
            end
          end
          3'b110:  r = {4'b0000, h[8:7], h[12], rs2, 5'd2, 3'b010, h[11:9], 2'b00, OP_STORE};
          default: ill = 1'b1;
        endcase
      end
      default: ;
    endcase
    return {ill, r};
  endfunction

  logic [15:0]      hw_buf [BUF_HW];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, push_n, pop_n, avail, free;
  logic             skip_lo;
  logic [PC_W-1:0]  head_pc;
  logic             push, load, head_c, complete, c_ill;
  logic [15:0]      in_lo, h0, h1;
  logic [31:0]      c_exp, c_instr, load_instr;

  // Incoming halfwords bypass the buffer so a word accepted this cycle can be issued this edge.
  always_comb begin
    free          = BUF_CNT - count;
    o_fetch_ready = (free >= CNT_W'(2));
    push          = i_fetch_valid && o_fetch_ready && !i_flush;
    in_lo         = skip_lo ? i_fetch_data[31:16] : i_fetch_data[15:0];
    push_n        = push ? (skip_lo ? CNT_W'(1) : CNT_W'(2)) : '0;
    avail         = count + push_n;
    h0            = (count != '0) ? hw_buf[rd_ptr] : in_lo;
    if (count >= CNT_W'(2))      h1 = hw_buf[rd_ptr + PTR_W'(1)];
    else if (count == CNT_W'(1)) h1 = in_lo;
    else                         h1 = i_fetch_data[31:16];
    head_c        = (h0[1:0] != 2'b11);
    complete      = head_c ? (avail >= CNT_W'(1)) : (avail >= CNT_W'(2));
    load          = (!o_valid || i_ready) && complete && !i_flush;
    pop_n         = load ? (head_c ? CNT_W'(1) : CNT_W'(2)) : '0;
    {c_ill, c_exp} = expand_c(h0);
`ifdef RV16C_ILLEGAL_TRAP_EN
    c_instr       = c_ill ? {16'h0000, h0} : c_exp;
`else
    c_instr       = c_ill ? NOP : c_exp;
`endif
    load_instr    = head_c ? c_instr : {h1, h0};
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      if (skip_lo) begin
        hw_buf[wr_ptr] <= i_fetch_data[31:16];
      end else begin
        hw_buf[wr_ptr]              <= i_fetch_data[15:0];
        hw_buf[wr_ptr + PTR_W'(1)]  <= i_fetch_data[31:16];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      skip_lo         <= RESET_PC[1];
      head_pc         <= RESET_PC;
      o_valid         <= 1'b0;
      o_instr         <= NOP;
      o_pc            <= RESET_PC;
      o_is_compressed <= 1'b0;
    end else if (i_flush) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      skip_lo         <= i_flush_pc[1];
      head_pc         <= i_flush_pc;
      o_valid         <= 1'b0;
      o_pc            <= i_flush_pc;
    end else begin
      if (push) skip_lo <= 1'b0;
      wr_ptr <= wr_ptr + push_n[PTR_W-1:0];
      rd_ptr <= rd_ptr + pop_n[PTR_W-1:0];
      count  <= count + push_n - pop_n;
      if (load) begin
        o_valid         <= 1'b1;
        o_instr         <= load_instr;
        o_pc            <= head_pc;
        o_is_compressed <= head_c;
        head_pc         <= head_pc + (head_c ? PC_W'(2) : PC_W'(4));
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef RV16C_ILLEGAL_TRAP_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        o_illegal <= 1'b0;
    else if (i_flush) o_illegal <= 1'b0;
    else if (load)    o_illegal <= head_c && c_ill;
  end
`else
  assign o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_rv16c_fetch_aligner.sv
// Bench for rv16c_fetch_aligner: directed steps then randomized traffic against a
// halfword-stream reference model with an RV32C decoder built from ISA field rules.
module tb_rv16c_fetch_aligner;
  localparam int PC_W = 32;
  localparam int W    = PC_W + 34;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            i_fetch_valid = 1'b0;
  logic [31:0]     i_fetch_data = '0;
  logic            o_fetch_ready;
  logic            i_flush = 1'b0;
  logic [PC_W-1:0] i_flush_pc = '0;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [31:0]     o_instr;
  logic [PC_W-1:0] o_pc;
  logic            o_is_compressed;
  logic            o_illegal;

  rv16c_fetch_aligner #(.BUF_HW(4), .PC_W(PC_W), .RESET_PC(32'h0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_fetch_valid(i_fetch_valid), .i_fetch_data(i_fetch_data),
    .o_fetch_ready(o_fetch_ready), .i_flush(i_flush), .i_flush_pc(i_flush_pc),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_pc(o_pc),
    .o_is_compressed(o_is_compressed), .o_illegal(o_illegal)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: {illegal, compressed, pc, instr}
  logic [W-1:0]    exp_q[$];
  logic [15:0]     pend[$];
  logic [PC_W-1:0] m_pc;
  logic            m_skip;
  logic            hold_pend;
  logic [31:0]     h_instr;
  logic [PC_W-1:0] h_pc;
  logic            h_c;
  logic            last_fire_f;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // ---- reference RV32C decoder from ISA field definitions ----
  function automatic int bits(input logic [15:0] h, input int hi, input int lo);
    int v;
    v = int'(h);
    return (v >> lo) & ((1 << (hi - lo + 1)) - 1);
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs1, input int f3);
    return {imm[12], imm[10:5], 5'd0, rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  function automatic logic [32:0] ref_c(input logic [15:0] h);
    int q, f3, rd, rs2, rdp, rs1p, u6, s6, off, b12;
    logic ill;
    logic [31:0] r;
    q = bits(h, 1, 0); f3 = bits(h, 15, 13); rd = bits(h, 11, 7); rs2 = bits(h, 6, 2);
    rdp = 8 + bits(h, 4, 2); rs1p = 8 + bits(h, 9, 7); b12 = bits(h, 12, 12);
    u6 = b12 * 32 + rs2; s6 = (u6 >= 32) ? u6 - 64 : u6;
    ill = 1'b0; r = 32'h13;
    if (q == 0) begin
      off = bits(h, 12, 10) * 8 + bits(h, 6, 6) * 4 + bits(h, 5, 5) * 64;
      if (f3 == 0) begin
        off = bits(h, 5, 5) * 8 + bits(h, 6, 6) * 4 + bits(h, 12, 11) * 16 + bits(h, 10, 7) * 64;
        if (off == 0) ill = 1'b1; else r = enc_i(off, 2, 0, rdp, 'h13);
      end else if (f3 == 2) r = enc_i(off, rs1p, 2, rdp, 'h03);
      else if (f3 == 6) r = enc_s(off, rdp, rs1p, 2);
      else ill = 1'b1;
    end else if (q == 1) begin
      if (f3 == 0) r = enc_i(s6, rd, 0, rd, 'h13);
      else if (f3 == 1 || f3 == 5) begin
        off = b12 * 2048 + bits(h, 11, 11) * 16 + bits(h, 10, 9) * 256 + bits(h, 8, 8) * 1024 +
              bits(h, 7, 7) * 64 + bits(h, 6, 6) * 128 + bits(h, 5, 3) * 2 + bits(h, 2, 2) * 32;
        if (off >= 2048) off -= 4096;
        r = enc_j(off, (f3 == 1) ? 1 : 0);
      end else if (f3 == 2) r = enc_i(s6, 0, 0, rd, 'h13);
      else if (f3 == 3) begin
        if (rd == 2) begin
          off = b12 * 512 + bits(h, 4, 3) * 128 + bits(h, 5, 5) * 64 + bits(h, 2, 2) * 32 + bits(h, 6, 6) * 16;
          if (off >= 512) off -= 1024;
          if (off == 0) ill = 1'b1; else r = enc_i(off, 2, 0, 2, 'h13);
        end else if (u6 == 0) ill = 1'b1;
        else r = {s6[19:0], rd[4:0], 7'h37};
      end else if (f3 == 4) begin
        case (bits(h, 11, 10))
          0: if (b12 == 1) ill = 1'b1; else r = enc_i(rs2, rs1p, 5, rs1p, 'h13);
          1: if (b12 == 1) ill = 1'b1; else r = enc_i(1024 + rs2, rs1p, 5, rs1p, 'h13);
          2: r = enc_i(s6, rs1p, 7, rs1p, 'h13);
          default: begin
            if (b12 == 1) ill = 1'b1;
            else case (bits(h, 6, 5))
              0: r = enc_r(32, rdp, rs1p, 0, rs1p);
              1: r = enc_r(0, rdp, rs1p, 4, rs1p);
              2: r = enc_r(0, rdp, rs1p, 6, rs1p);
              default: r = enc_r(0, rdp, rs1p, 7, rs1p);
            endcase
          end
        endcase
      end else begin
        off = b12 * 256 + bits(h, 6, 5) * 64 + bits(h, 2, 2) * 32 + bits(h, 11, 10) * 8 + bits(h, 4, 3) * 2;
        if (off >= 256) off -= 512;
        r = enc_b(off, rs1p, (f3 == 6) ? 0 : 1);
      end
    end else begin
      if (f3 == 0) begin
        if (b12 == 1) ill = 1'b1; else r = enc_i(rs2, rd, 1, rd, 'h13);
      end else if (f3 == 2) begin
        off = b12 * 32 + bits(h, 6, 4) * 4 + bits(h, 3, 2) * 64;
        if (rd == 0) ill = 1'b1; else r = enc_i(off, 2, 2, rd, 'h03);
      end else if (f3 == 4) begin
        if (b12 == 0 && rs2 != 0) r = enc_r(0, rs2, 0, 0, rd);
        else if (b12 == 0 && rd == 0) ill = 1'b1;
        else if (b12 == 0) r = enc_i(0, rd, 0, 0, 'h67);
        else if (rs2 != 0) r = enc_r(0, rs2, rd, 0, rd);
        else if (rd == 0) r = 32'h0010_0073;
        else r = enc_i(0, rd, 0, 1, 'h67);
      end else if (f3 == 6) r = enc_s(bits(h, 12, 9) * 4 + bits(h, 8, 7) * 64, rs2, 2, 2);
      else ill = 1'b1;
    end
`ifdef RV16C_ILLEGAL_TRAP_EN
    if (ill) r = {16'h0000, h};
`else
    if (ill) r = 32'h13;
`endif
    return {ill, r};
  endfunction

  // ---- reference stream model ----
  task automatic model_push(input logic [31:0] fd);
    logic [32:0] e;
    logic        ill_o;
    if (m_skip) pend.push_back(fd[31:16]);
    else begin pend.push_back(fd[15:0]); pend.push_back(fd[31:16]); end
    m_skip = 1'b0;
    while (pend.size() > 0) begin
      if (pend[0][1:0] != 2'b11) begin
        e = ref_c(pend[0]);
`ifdef RV16C_ILLEGAL_TRAP_EN
        ill_o = e[32];
`else
        ill_o = 1'b0;
`endif
        exp_q.push_back({ill_o, 1'b1, m_pc, e[31:0]});
        void'(pend.pop_front());
        m_pc += 2;
      end else if (pend.size() >= 2) begin
        exp_q.push_back({1'b0, 1'b0, m_pc, pend[1], pend[0]});
        void'(pend.pop_front());
        void'(pend.pop_front());
        m_pc += 4;
      end else break;
    end
  endtask

  task automatic model_flush(input logic [PC_W-1:0] pc);
    pend.delete();
    exp_q.delete();
    m_pc   = pc;
    m_skip = pc[1];
  endtask

  // ---- driver: one cycle; inputs set after negedge, outputs sampled before posedge ----
  task automatic tick(input logic fv, input logic [31:0] fd, input logic rdy, input logic fl,
                      input logic [PC_W-1:0] fpc);
    logic fire_f, fire_o;
    logic [W-1:0] e;
    i_fetch_valid = fv; i_fetch_data = fd; i_ready = rdy; i_flush = fl; i_flush_pc = fpc;
    #1;
    fire_f = fv && o_fetch_ready && !fl;
    fire_o = o_valid && rdy && !fl;
    if (hold_pend) begin
      chk("hold_valid", 64'(o_valid), 64'd1);
      chk("hold_instr", 64'(o_instr), 64'(h_instr));
      chk("hold_pc", 64'(o_pc), 64'(h_pc));
      chk("hold_c", 64'(o_is_compressed), 64'(h_c));
    end
    if (fire_o) begin
      if (exp_q.size() == 0) chk("unexpected_out_pc", 64'(o_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("out_instr", 64'(o_instr), 64'(e[31:0]));
        chk("out_pc", 64'(o_pc), 64'(e[PC_W+31:32]));
        chk("out_c", 64'(o_is_compressed), 64'(e[PC_W+32]));
        chk("out_illegal", 64'(o_illegal), 64'(e[PC_W+33]));
      end
    end
    hold_pend = o_valid && !rdy && !fl;
    h_instr = o_instr; h_pc = o_pc; h_c = o_is_compressed;
    last_fire_f = fire_f;
    @(posedge i_clk);
    if (fl) model_flush(fpc);
    else if (fire_f) model_push(fd);
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b1, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_fetch_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
    i_rst = 1'b1;
    #2;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_instr", 64'(o_instr), 64'h13);
    chk("rst_pc", 64'(o_pc), 64'd0);
    chk("rst_c", 64'(o_is_compressed), 64'd0);
    chk("rst_illegal", 64'(o_illegal), 64'd0);
    chk("rst_fetch_ready", 64'(o_fetch_ready), 64'd1);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_flush(32'h0);
    hold_pend = 1'b0;
  endtask

  initial begin
    logic [31:0] word;
    logic [PC_W-1:0] fpc;
    hold_pend = 1'b0;
    last_fire_f = 1'b0;
    model_flush(32'h0);
    #1;
    do_reset();

    // two compressed instructions from one word; issue the cycle after acceptance
    tick(1'b1, 32'h0001_0405, 1'b1, 1'b0, '0);
    chk("lat_valid", 64'(o_valid), 64'd1);
    chk("lat_instr", 64'(o_instr), 64'h0014_0413);
    idle(3);

    // 32-bit instruction straddling two fetch words
    tick(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    tick(1'b1, 32'h0513_4501, 1'b1, 1'b0, '0);
    tick(1'b1, 32'h4501_0010, 1'b1, 1'b0, '0);
    chk("straddle_instr", 64'(o_instr), 64'h0010_0513);
    chk("straddle_c", 64'(o_is_compressed), 64'd0);
    chk("straddle_pc", 64'(o_pc), 64'd2);
    idle(3);

    // flush to an odd halfword: the low halfword of the next word is skipped
    tick(1'b0, 32'h0, 1'b1, 1'b1, 32'h102);
    tick(1'b1, 32'h4501_0405, 1'b1, 1'b0, '0);
    chk("skip_pc", 64'(o_pc), 64'h102);
    chk("skip_instr", 64'(o_instr), 64'h0000_0513);
    idle(3);
    chk("skip_single", 64'(o_valid), 64'd0);
    chk("skip_drained", 64'(exp_q.size()), 64'd0);

    // backpressure: buffer fills, ready drops, outputs held, then drain
    tick(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    tick(1'b1, 32'h0001_0405, 1'b0, 1'b0, '0);
    tick(1'b1, 32'h0001_0405, 1'b0, 1'b0, '0);
    #1;
    chk("bp_ready_low", 64'(o_fetch_ready), 64'd0);
    tick(1'b1, 32'h0001_0405, 1'b0, 1'b0, '0);
    chk("bp_not_accepted", 64'(last_fire_f), 64'd0);
    idle(6);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // reset with data in flight
    tick(1'b1, 32'h0001_0405, 1'b0, 1'b0, '0);
    do_reset();
    idle(2);
    chk("rst_mid_empty", 64'(o_valid), 64'd0);

    // all-zero halfword is illegal
    tick(1'b1, 32'h0000_0000, 1'b1, 1'b0, '0);
`ifdef RV16C_ILLEGAL_TRAP_EN
    chk("ill_instr", 64'(o_instr), 64'h0);
    chk("ill_flag", 64'(o_illegal), 64'd1);
`else
    chk("ill_instr", 64'(o_instr), 64'h13);
    chk("ill_flag", 64'(o_illegal), 64'd0);
`endif
    idle(3);

    // flush in the same cycle as fetch accept and output handshake
    tick(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    tick(1'b1, 32'h0001_0405, 1'b1, 1'b0, '0);
    tick(1'b1, 32'h4501_4501, 1'b1, 1'b1, 32'h40);
    chk("fl_valid", 64'(o_valid), 64'd0);
    chk("fl_ready", 64'(o_fetch_ready), 64'd1);
    chk("fl_pc", 64'(o_pc), 64'h40);
    idle(2);
    chk("fl_empty", 64'(o_valid), 64'd0);

    // randomized traffic
    word = $urandom;
    for (int i = 0; i < 3000; i++) begin
      fpc = PC_W'($urandom_range(0, 2047)) << 1;
      tick(1'($urandom_range(0, 3) != 0), word, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 63) == 0), fpc);
      if (last_fire_f) word = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
    end
    idle(20);
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
